// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Purpose  : Handshaked ALU with nine function codes on WIDTH-bit unsigned
//            operands. Logic/ADD/SUB complete in one cycle; MUL (shift-add)
//            and DIV (restoring) iterate one bit per cycle.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk       in   1        rising-edge clock
//   rst_n     in   1        asynchronous active-low reset
//   in_valid  in   1        command (a, b, f) presented
//   in_ready  out  1        command accepted this cycle (IDLE only)
//   a, b      in   WIDTH    unsigned operands
//   f         in   4        function code (0..8 legal, 9..15 -> err)
//   out_valid out  1        result registered and stable
//   out_ready in   1        consumer takes result
//   y         out  2*WIDTH  result (DIV: {remainder, quotient})
//   zero      out  1        y == 0
//   carry     out  1        ADD carry / SUB borrow, 0 otherwise
//   err       out  1        divide by zero or undefined f
// ============================================================================
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [3:0]         f,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] y,
  output logic               zero,
  output logic               carry,
  output logic               err
);

  localparam int                c_cnt_w    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic                 r_is_div;
  // Shared iteration registers: MUL {accumulator, multiplier},
  // DIV {partial remainder, dividend/quotient}.
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic [2*WIDTH-1:0]   r_y;
  logic                 r_zero;
  logic                 r_carry;
  logic                 r_err;
  logic                 r_out_valid;

  logic                 w_accept;
  logic                 w_iterative;
  logic                 w_last;
  logic [WIDTH:0]       w_sum;
  logic [WIDTH:0]       w_dif;
  logic [2*WIDTH-1:0]   w_imm_y;
  logic                 w_imm_carry;
  logic                 w_imm_err;
  logic [WIDTH:0]       w_mul_sum;
  logic [WIDTH:0]       w_shift;
  logic                 w_ge;
  logic [WIDTH-1:0]     w_rem_sub;
  logic [WIDTH-1:0]     w_step_hi;
  logic [WIDTH-1:0]     w_step_lo;

  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = r_out_valid;
  assign y           = r_y;
  assign zero        = r_zero;
  assign carry       = r_carry;
  assign err         = r_err;

  assign w_accept    = in_valid && in_ready;
  // Divide by zero resolves immediately, so only a real divide iterates.
  assign w_iterative = (f == 4'd7) || ((f == 4'd8) && (b != '0));
  assign w_last      = (r_cnt == c_cnt_last);

  // Single-cycle result path, evaluated on the raw inputs at accept.
  assign w_sum = {1'b0, a} + {1'b0, b};
  assign w_dif = {1'b0, a} - {1'b0, b};

  always_comb begin
    w_imm_y     = '0;
    w_imm_carry = 1'b0;
    w_imm_err   = 1'b0;
    case (f)
      4'd0: w_imm_y = {{WIDTH{1'b0}}, a & b};
      4'd1: w_imm_y = {{WIDTH{1'b0}}, a | b};
      4'd2: w_imm_y = {{WIDTH{1'b0}}, a ^ b};
      4'd3: w_imm_y = {{WIDTH{1'b0}}, ~(a & b)};
      4'd4: w_imm_y = {{WIDTH{1'b0}}, ~(a | b)};
      4'd5: begin
        w_imm_y     = {{(WIDTH-1){1'b0}}, w_sum};
        w_imm_carry = w_sum[WIDTH];
      end
      4'd6: begin
        w_imm_y     = {{(WIDTH-1){1'b0}}, w_dif};
        w_imm_carry = w_dif[WIDTH];
      end
      4'd7: w_imm_y = '0;
      4'd8: begin
        // Only reached with b == 0: quotient all ones, remainder = a.
        w_imm_y   = {a, {WIDTH{1'b1}}};
        w_imm_err = 1'b1;
      end
      default: w_imm_err = 1'b1;
    endcase
  end

  // Shift-add multiply step: add multiplicand when the multiplier LSB is set,
  // then shift the {carry, accumulator, multiplier} chain right by one.
  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);

  // Restoring divide step: bring in the next dividend bit, subtract if it fits.
  // The partial remainder stays below 2*b, so the difference fits WIDTH bits.
  assign w_shift   = {r_hi, r_lo[WIDTH-1]};
  assign w_ge      = (w_shift >= {1'b0, r_b});
  assign w_rem_sub = w_shift[WIDTH-1:0] - r_b;

  always_comb begin
    if (r_is_div) begin
      w_step_hi = w_ge ? w_rem_sub : w_shift[WIDTH-1:0];
      w_step_lo = {r_lo[WIDTH-2:0], w_ge};
    end else begin
      w_step_hi = w_mul_sum[WIDTH:1];
      w_step_lo = {w_mul_sum[0], r_lo[WIDTH-1:1]};
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)  w_next_state = w_iterative ? S_BUSY : S_DONE;
      S_BUSY:  if (w_last)    w_next_state = S_DONE;
      S_DONE:  if (out_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_is_div    <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_y         <= '0;
      r_zero      <= 1'b0;
      r_carry     <= 1'b0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= (w_next_state == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a      <= a;
            r_b      <= b;
            r_is_div <= (f == 4'd8);
            r_cnt    <= '0;
            if (w_iterative) begin
              r_hi <= '0;
              r_lo <= (f == 4'd8) ? a : b;
            end else begin
              r_y     <= w_imm_y;
              r_zero  <= (w_imm_y == '0);
              r_carry <= w_imm_carry;
              r_err   <= w_imm_err;
            end
          end
        end
        S_BUSY: begin
          r_hi <= w_step_hi;
          r_lo <= w_step_lo;
          if (w_last) begin
            r_cnt   <= '0;
            r_y     <= {w_step_hi, w_step_lo};
            r_zero  <= ({w_step_hi, w_step_lo} == '0);
            r_carry <= 1'b0;
            r_err   <= 1'b0;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
